// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the memory-stage controller and the data memory.
// The controller is the master. It issues req/we/addr/wdata and holds them
// stable until ready is seen. The memory is the slave and returns ready, plus
// rdata for reads.
interface mem_stage_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller.
// It takes the EX/MEM pipeline register outputs and drives the data-memory
// bus through a valid/ready handshake. While an access is outstanding it
// stalls the upstream stages. It also resolves branch/jump redirects and
// registers results into the MEM/WB boundary.
//
// An access that completes in the cycle it is issued costs no stall. An access
// that has to wait has all of its EX/MEM fields latched, so the bus request
// and the eventual write-back do not depend on the held upstream registers. A
// wait that runs too long is aborted. In that case the load data is forced to
// zero and a sticky error flag is set.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             adder_in,
    input  logic [31:0]             alu_result_in,
    input  logic                    zero_in,
    input  logic [31:0]             writedata_in,
    input  logic [4:0]              rd_in,
    input  logic                    branch_in,
    input  logic                    memtoreg_in,
    input  logic                    memwrite_in,
    input  logic                    regwrite_in,
    input  logic                    addermuxselect_in,
    mem_stage_ctrl_if.master        dmem,
    output logic                    stall,
    output logic                    flush,
    output logic [31:0]             pc_target,
    output logic [31:0]             wb_data,
    output logic [4:0]              wb_rd,
    output logic                    wb_regwrite,
    output logic                    err_misalign,
    output logic                    err_timeout
);

    // The last wait cycle allowed before the access is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST_C = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO_C = CNT_W'(0);

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        WAIT_S = 1'b1
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;

    // Request and write-back context held while the bus access is outstanding.
    logic               lat_we_r;
    logic [31:0]        lat_addr_r;
    logic [31:0]        lat_wdata_r;
    logic [4:0]         lat_rd_r;
    logic               lat_regwrite_r;
    logic               lat_is_load_r;
    logic               lat_redirect_r;
    logic [31:0]        lat_target_r;

    // Decode of the instruction currently sitting in EX/MEM.
    logic               mem_op_s;
    logic               is_store_s;
    logic               is_load_s;
    logic               redirect_s;
    logic               misalign_s;

    // Per-cycle events and the next MEM/WB contents.
    logic               complete_s;
    logic               start_wait_s;
    logic               abort_s;
    logic               sel_redirect_s;
    logic [31:0]        sel_target_s;
    logic [31:0]        nxt_wb_data_s;
    logic [4:0]         nxt_wb_rd_s;
    logic               nxt_wb_regwrite_s;

    // Decode the EX/MEM control bits. A load+store combination counts as a store.
    always_comb begin
        mem_op_s   = memtoreg_in | memwrite_in;
        is_store_s = memwrite_in;
        is_load_s  = memtoreg_in & ~memwrite_in;
        redirect_s = (branch_in & zero_in) | addermuxselect_in;
        misalign_s = mem_op_s & (alu_result_in[1:0] != 2'b00);
    end

    // Bus drive, stall/flush generation and selection of the next MEM/WB values.
    always_comb begin
        dmem.req          = 1'b0;
        dmem.we           = 1'b0;
        dmem.addr         = 32'h0000_0000;
        dmem.wdata        = 32'h0000_0000;
        stall             = 1'b0;
        flush             = 1'b0;
        pc_target         = 32'h0000_0000;
        complete_s        = 1'b0;
        start_wait_s      = 1'b0;
        abort_s           = 1'b0;
        sel_redirect_s    = 1'b0;
        sel_target_s      = 32'h0000_0000;
        nxt_wb_data_s     = wb_data;
        nxt_wb_rd_s       = wb_rd;
        nxt_wb_regwrite_s = 1'b0;
        if (!reset) begin
            case (state_r)
                IDLE_S: begin
                    sel_redirect_s    = redirect_s;
                    sel_target_s      = adder_in;
                    nxt_wb_rd_s       = rd_in;
                    nxt_wb_regwrite_s = regwrite_in & ~misalign_s;
                    if (mem_op_s && !misalign_s) begin
                        dmem.req   = 1'b1;
                        dmem.we    = is_store_s;
                        dmem.addr  = alu_result_in;
                        dmem.wdata = writedata_in;
                        if (dmem.ready) begin
                            complete_s    = 1'b1;
                            nxt_wb_data_s = is_load_s ? dmem.rdata : alu_result_in;
                        end else begin
                            stall        = 1'b1;
                            start_wait_s = 1'b1;
                        end
                    end else begin
                        // A non-memory op or a misaligned op completes with no bus access.
                        // A misaligned load has no data to return, so it writes back zero.
                        complete_s    = 1'b1;
                        nxt_wb_data_s = is_load_s ? 32'h0000_0000 : alu_result_in;
                    end
                end
                WAIT_S: begin
                    dmem.req          = 1'b1;
                    dmem.we           = lat_we_r;
                    dmem.addr         = lat_addr_r;
                    dmem.wdata        = lat_wdata_r;
                    sel_redirect_s    = lat_redirect_r;
                    sel_target_s      = lat_target_r;
                    nxt_wb_rd_s       = lat_rd_r;
                    nxt_wb_regwrite_s = lat_regwrite_r;
                    if (dmem.ready) begin
                        complete_s    = 1'b1;
                        nxt_wb_data_s = lat_is_load_r ? dmem.rdata : lat_addr_r;
                    end else if (cnt_r == CNT_LAST_C) begin
                        complete_s    = 1'b1;
                        abort_s       = 1'b1;
                        nxt_wb_data_s = lat_is_load_r ? 32'h0000_0000 : lat_addr_r;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
            // Redirect only on the completion cycle, so the flush never overlaps a stall.
            flush     = complete_s & sel_redirect_s;
            pc_target = flush ? sel_target_s : 32'h0000_0000;
        end else begin
            stall = 1'b0;
        end
    end

    // State machine, wait counter, access context, MEM/WB register and sticky errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE_S;
            cnt_r          <= CNT_ZERO_C;
            lat_we_r       <= 1'b0;
            lat_addr_r     <= 32'h0000_0000;
            lat_wdata_r    <= 32'h0000_0000;
            lat_rd_r       <= 5'd0;
            lat_regwrite_r <= 1'b0;
            lat_is_load_r  <= 1'b0;
            lat_redirect_r <= 1'b0;
            lat_target_r   <= 32'h0000_0000;
            wb_data        <= 32'h0000_0000;
            wb_rd          <= 5'd0;
            wb_regwrite    <= 1'b0;
            err_misalign   <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE_S: begin
                    cnt_r <= CNT_ZERO_C;
                    if (start_wait_s) begin
                        state_r        <= WAIT_S;
                        lat_we_r       <= is_store_s;
                        lat_addr_r     <= alu_result_in;
                        lat_wdata_r    <= writedata_in;
                        lat_rd_r       <= rd_in;
                        lat_regwrite_r <= regwrite_in;
                        lat_is_load_r  <= is_load_s;
                        lat_redirect_r <= redirect_s;
                        lat_target_r   <= adder_in;
                    end else begin
                        state_r <= IDLE_S;
                    end
                end
                WAIT_S: begin
                    if (complete_s) begin
                        state_r <= IDLE_S;
                        cnt_r   <= CNT_ZERO_C;
                    end else begin
                        state_r <= WAIT_S;
                        cnt_r   <= cnt_r + CNT_ONE_C;
                    end
                end
                default: begin
                    state_r <= IDLE_S;
                    cnt_r   <= CNT_ZERO_C;
                end
            endcase

            // A stalled cycle leaves a bubble: data and rd hold, and the write enable drops.
            if (complete_s) begin
                wb_data     <= nxt_wb_data_s;
                wb_rd       <= nxt_wb_rd_s;
                wb_regwrite <= nxt_wb_regwrite_s;
            end else begin
                wb_regwrite <= 1'b0;
            end

            if (misalign_s && (state_r == IDLE_S)) begin
                err_misalign <= 1'b1;
            end else begin
                err_misalign <= err_misalign;
            end

            if (abort_s) begin
                err_timeout <= 1'b1;
            end else begin
                err_timeout <= err_timeout;
            end
        end
    end

endmodule
